// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams operand pairs onto the MAC pins and returns the captured dot-product result
module mac_dot_sequencer #(
  parameter int VEC_LEN    = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [6:0]  in_b,
  output logic [7:0]  mac_a,
  output logic [6:0]  mac_b,
  output logic        mac_clear_mult,
  input  logic [14:0] mac_result,
  input  logic        mac_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [14:0] res_data,
  output logic        res_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FEED, WAIT, HOLD} state_t;
  state_t     state;
  logic [7:0] count;
  logic [2:0] lat;
  logic       take;
  assign in_ready = state == IDLE || state == FEED;
  assign busy     = state != IDLE;
  assign take     = in_ready && in_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      lat            <= '0;
      mac_a          <= '0;
      mac_b          <= '0;
      mac_clear_mult <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_ovf        <= 1'b0;
    end else begin
      // zero pins whenever no pair is taken so the MAC accumulate is a no-op
      mac_a          <= take ? in_a : '0;
      mac_b          <= take ? in_b : '0;
      mac_clear_mult <= take && state == IDLE;
      case (state)
        IDLE: if (in_valid) begin
          count <= 8'd1;
          lat   <= 3'(RESULT_LAT);
          state <= VEC_LEN == 1 ? WAIT : FEED;
        end
        FEED: if (in_valid) begin
          count <= count + 8'd1;
          lat   <= 3'(RESULT_LAT);
          if (count + 8'd1 == 8'(VEC_LEN)) state <= WAIT;
        end
        WAIT: if (lat == 3'd0) begin
          res_data  <= mac_result;
          res_ovf   <= mac_ovf;
          res_valid <= 1'b1;
          state     <= HOLD;
        end else lat <= lat - 3'd1;
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: scoreboard bench with a pin-level MAC model, two parameter sets
module tb_mac_dot_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0, done_cnt = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int VL = g == 0 ? 4 : 1;
    localparam int RL = g == 0 ? 1 : 3;
    logic        rst, in_valid, in_ready, mac_clear_mult, mac_ovf, res_valid, res_ovf, busy;
    logic        res_ready = 1'b0;
    logic [7:0]  in_a, mac_a;
    logic [6:0]  in_b, mac_b;
    logic [14:0] mac_result, res_data;
    mac_dot_sequencer #(.VEC_LEN(VL), .RESULT_LAT(RL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_clear_mult(mac_clear_mult), .mac_result(mac_result),
      .mac_ovf(mac_ovf), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .busy(busy)
    );
    // MAC model: acc loads or accumulates the pins each edge; result visible RL edges after sampling
    logic [14:0] acc = '0;
    logic        ovf = 1'b0;
    logic [15:0] prod, sum;
    logic        ovf_n;
    logic [15:0] pipe [8];
    always_comb begin
      prod  = 16'(mac_a) * 16'(mac_b);
      sum   = (mac_clear_mult ? 16'd0 : {1'b0, acc}) + prod;
      ovf_n = mac_clear_mult ? sum[15] : (ovf | sum[15]);
    end
    always @(posedge clk) begin
      acc     <= sum[14:0];
      ovf     <= ovf_n;
      pipe[0] <= {ovf_n, sum[14:0]};
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign {mac_ovf, mac_result} = pipe[RL-1];
    logic [15:0] exp_q[$];
    int          edge_q[$];
    logic        take_d = 1'b0, pv = 1'b0;
    logic [16:0] pd = '0;
    always @(posedge clk) take_d <= !rst && in_valid && in_ready;
    always @(negedge clk) begin
      if (!take_d) chk("pins_zero", int'({mac_a, mac_b, mac_clear_mult}), 0);
      if (rst) begin
        pv        <= 1'b0;
        res_ready <= 1'b0;
      end else begin
        if (res_valid && !pv) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            chk("res_data", int'(res_data), int'(exp_q[0][14:0]));
            chk("res_ovf", int'(res_ovf), int'(exp_q[0][15]));
            chk("res_edge", cyc, edge_q[0]);
            void'(exp_q.pop_front());
            void'(edge_q.pop_front());
          end
        end
        if (res_valid) chk("res_in_ready", int'(in_ready), 0);
        if (pv && !res_ready) chk("res_hold", int'({res_valid, res_ovf, res_data}), int'(pd));
        if (pv && res_ready) begin
          chk("res_drop", int'(res_valid), 0);
          chk("idle_after", int'(busy), 0);
        end
        pv        <= res_valid;
        pd        <= {res_valid, res_ovf, res_data};
        res_ready <= $urandom_range(0, 4) == 0;
      end
    end
    task automatic vec(input int mode, input int gap_at, input int abort_at);
      int s;
      int t;
      logic [7:0] a;
      logic [6:0] b;
      s = 0;
      for (int e = 0; e < VL; e++) begin
        if (e == abort_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk("abort_pins", int'({mac_a, mac_b, mac_clear_mult}), 0);
          chk("abort_valid", int'(res_valid), 0);
          chk("abort_busy", int'(busy), 0);
          return;
        end
        if (e == gap_at) begin
          repeat (3) @(posedge clk);
          #1;
        end
        if (mode == 0 && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        a = mode == 1 ? 8'(e + 1) : mode == 2 ? 8'd255 : mode == 3 ? 8'd1 :
            mode == 4 ? 8'd2 : mode == 5 ? 8'd10 : 8'($urandom);
        b = mode == 1 ? 7'(e + 5) : mode == 2 ? 7'd127 : mode == 3 ? 7'd1 :
            mode == 4 ? 7'd3 : mode == 5 ? 7'd12 : 7'($urandom);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 300) begin
          @(negedge clk);
          t++;
        end
        chk("accept_wait", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pin_a", int'(mac_a), int'(a));
        chk("pin_b", int'(mac_b), int'(b));
        chk("pin_clr", int'(mac_clear_mult), int'(e == 0));
        s += int'(a) * int'(b);
        if (e == VL - 1) begin
          exp_q.push_back({s > 32767, s[14:0]});
          edge_q.push_back(cyc + 1 + RL);
          chk("wait_ready", int'(in_ready), 0);
        end
      end
    endtask
    initial begin
      int t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_pins", int'({mac_a, mac_b, mac_clear_mult}), 0);
      chk("rst_res", int'({res_valid, res_ovf, res_data}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 1);
      if (VL == 4) begin
        vec(1, -1, -1);
        vec(1, 2, -1);
        vec(2, -1, -1);
        vec(3, -1, -1);
        vec(1, -1, 2);
        vec(4, -1, -1);
      end else vec(5, -1, -1);
      repeat (25) vec(0, -1, -1);
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("drain", exp_q.size(), 0);
      done_cnt++;
    end
  end
  initial begin
    int t;
    t = 0;
    while (done_cnt < 2 && t < 50000) begin
      @(posedge clk);
      t++;
    end
    chk("bench_timeout", done_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
